icu_ibuf: RTL and testbench

Byte-granular instruction buffer in the ICU. It accepts 4-byte fetch words from the instruction cache and presents the oldest 7 bytes to the decode/length logic. It retires bytes according to the one-hot shift code `iu_shift_d` returned by the IU decode stage. It also realigns after a flush and flags illegal shift codes.

---
 rtl/icu_ibuf_pkg.sv | 15 +
 rtl/ibuf_shift_dec.sv | 18 +
 rtl/icu_ibuf.sv | 130 +++++++++++++
 tb/tb_icu_ibuf.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/icu_ibuf_pkg.sv
// rtl/icu_ibuf_pkg.sv - shared constants and FSM state type for the ICU instruction buffer
package icu_ibuf_pkg;

  localparam int IBUF_DEPTH   = 16;
  localparam int IBUF_FETCH_W = 4;
  localparam int IBUF_WIN     = 7;
  localparam int IBUF_PTR_W   = $clog2(IBUF_DEPTH);
  localparam int IBUF_CNT_W   = IBUF_PTR_W + 1;

  typedef enum logic {
    IBUF_NORMAL = 1'b0,
    IBUF_ALIGN  = 1'b1
  } ibuf_state_e;

endpackage

// File: rtl/ibuf_shift_dec.sv
// rtl/ibuf_shift_dec.sv - one-hot retire code to binary count with illegal-code flag (combinational)
module ibuf_shift_dec (
  input  logic [7:0] code_i,
  output logic [2:0] cnt_o,
  output logic       illegal_o
);

  always_comb begin
    cnt_o     = 3'd0;
    illegal_o = (code_i == 8'd0) || ((code_i & (code_i - 8'd1)) != 8'd0);
    if (!illegal_o) begin
      for (int k = 0; k < 8; k++) begin
        if (code_i[k]) cnt_o = 3'(k);
      end
    end
  end

endmodule

// File: rtl/icu_ibuf.sv
// rtl/icu_ibuf.sv - byte-granular instruction buffer feeding decode; ICU_IBUF_BYPASS_EN adds a
// combinational fill path from the fetch word to the output window.
module icu_ibuf
  import icu_ibuf_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic [31:0]            ic_data,
  input  logic                   ic_vld,
  output logic                   ibuf_rdy,
  input  logic [7:0]             iu_shift_d,
  input  logic                   iu_flush,
  input  logic [1:0]             flush_pc_lo,
  output logic [55:0]            ibuf_bytes,
  output logic [6:0]             ibuf_vld,
  output logic [$clog2(DEPTH):0] ibuf_cnt,
  output logic                   ibuf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ibuf_state_e   state_q, state_d;
  logic [1:0]    align_off_q, align_off_d;
  logic          err_q, err_d;

  logic [2:0]    dec_cnt;
  logic          dec_ill;
  logic [CW-1:0] s_raw, s_eff;
  logic          accept;
  logic [1:0]    drop;
  logic [2:0]    wbytes;

  ibuf_shift_dec u_shift_dec (
    .code_i    (iu_shift_d),
    .cnt_o     (dec_cnt),
    .illegal_o (dec_ill)
  );

  // Readiness looks only at registered count, so a same-cycle retire never over-fills.
  assign ibuf_rdy = (cnt_q <= CW'(DEPTH - IBUF_FETCH_W));
  assign accept   = ic_vld & ibuf_rdy & ~iu_flush;
  assign drop     = (state_q == IBUF_ALIGN) ? align_off_q : 2'd0;
  assign wbytes   = 3'd4 - {1'b0, drop};
  assign s_raw    = CW'(dec_cnt);
  assign s_eff    = (s_raw > cnt_q) ? cnt_q : s_raw;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    align_off_d = align_off_q;
    err_d       = err_q;
    if (iu_flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      cnt_d       = '0;
      align_off_d = flush_pc_lo;
      state_d     = IBUF_ALIGN;
    end else begin
      err_d    = err_q | dec_ill | (s_raw > cnt_q);
      rd_ptr_d = rd_ptr_q + PW'(s_eff);
      cnt_d    = cnt_q - s_eff + (accept ? CW'(wbytes) : CW'(0));
      if (accept) begin
        wr_ptr_d = wr_ptr_q + PW'(wbytes);
        state_d  = IBUF_NORMAL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= IBUF_NORMAL;
      align_off_q <= 2'd0;
      err_q       <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      align_off_q <= align_off_d;
      err_q       <= err_d;
    end
  end

  // Storage needs no reset: slots beyond cnt_q are masked on the output.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < IBUF_FETCH_W; j++) begin
        if (j >= int'(drop)) mem_q[wr_ptr_q + PW'(j - int'(drop))] <= ic_data[8*(3-j) +: 8];
      end
    end
  end

  always_comb begin
    ibuf_bytes = '0;
    ibuf_vld   = '0;
    ibuf_cnt   = cnt_q;
    for (int i = 0; i < IBUF_WIN; i++) begin
      if (CW'(i) < cnt_q) begin
        ibuf_vld[i]         = 1'b1;
        ibuf_bytes[8*i +: 8] = mem_q[rd_ptr_q + PW'(i)];
      end
    end
`ifdef ICU_IBUF_BYPASS_EN
    if (accept) begin
      ibuf_cnt = cnt_q + CW'(wbytes);
      for (int j = 0; j < IBUF_FETCH_W; j++) begin
        if ((j >= int'(drop)) && (int'(cnt_q) + j - int'(drop) < IBUF_WIN)) begin
          ibuf_vld[int'(cnt_q) + j - int'(drop)]                = 1'b1;
          ibuf_bytes[8*(int'(cnt_q) + j - int'(drop)) +: 8] = ic_data[8*(3-j) +: 8];
        end
      end
    end
`endif
  end

  assign ibuf_err = err_q;

endmodule

// File: tb/tb_icu_ibuf.sv
// tb/tb_icu_ibuf.sv - scoreboard bench for icu_ibuf against a byte-queue reference model
module tb_icu_ibuf;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic [31:0] ic_data = '0;
  logic        ic_vld = 1'b0;
  logic        ibuf_rdy;
  logic [7:0]  iu_shift_d = 8'h01;
  logic        iu_flush = 1'b0;
  logic [1:0]  flush_pc_lo = 2'd0;
  logic [55:0] ibuf_bytes;
  logic [6:0]  ibuf_vld;
  logic [4:0]  ibuf_cnt;
  logic        ibuf_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]  cnt;
    logic [6:0]  vld;
    logic [55:0] bytes;
    logic        rdy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  byte unsigned mq[$];
  bit           m_align;
  bit [1:0]     m_off;
  bit           m_err;

  icu_ibuf dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .ic_data     (ic_data),
    .ic_vld      (ic_vld),
    .ibuf_rdy    (ibuf_rdy),
    .iu_shift_d  (iu_shift_d),
    .iu_flush    (iu_flush),
    .flush_pc_lo (flush_pc_lo),
    .ibuf_bytes  (ibuf_bytes),
    .ibuf_vld    (ibuf_vld),
    .ibuf_cnt    (ibuf_cnt),
    .ibuf_err    (ibuf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.cnt   = 5'(mq.size());
    e.vld   = '0;
    e.bytes = '0;
    for (int i = 0; i < 7; i++) begin
      if (i < mq.size()) begin
        e.vld[i]          = 1'b1;
        e.bytes[8*i +: 8] = mq[i];
      end
    end
    e.rdy = (16 - mq.size()) >= 4;
    e.err = m_err;
    return e;
  endfunction

  task automatic model_step(input bit rst, input bit vld, input logic [31:0] data,
                            input logic [7:0] sh, input bit fl, input logic [1:0] pc);
    int s;
    bit rdy;
    int drop;
    if (rst) begin
      mq.delete();
      m_align = 1'b0;
      m_off   = 2'd0;
      m_err   = 1'b0;
    end else if (fl) begin
      mq.delete();
      m_align = 1'b1;
      m_off   = pc;
    end else begin
      s = 0;
      if ($countones(sh) != 1) m_err = 1'b1;
      else for (int k = 0; k < 8; k++) if (sh[k]) s = k;
      if (s > mq.size()) begin
        s     = mq.size();
        m_err = 1'b1;
      end
      rdy = (16 - mq.size()) >= 4;
      repeat (s) void'(mq.pop_front());
      if (vld && rdy) begin
        drop = m_align ? int'(m_off) : 0;
        for (int j = drop; j < 4; j++) mq.push_back(data[8*(3-j) +: 8]);
        m_align = 1'b0;
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit vld, input logic [31:0] data,
                     input logic [7:0] sh, input bit fl, input logic [1:0] pc);
    @(negedge clk);
    #1;
    reset_l     = !rst;
    ic_vld      = vld;
    ic_data     = data;
    iu_shift_d  = sh;
    iu_flush    = fl;
    flush_pc_lo = pc;
    model_step(rst, vld, data, sh, fl, pc);
    exp_q.push_back(model_view());
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #2;
    reset_l = 1'b0;
    #1;
    chk("async_rst_cnt", 64'(ibuf_cnt), 64'd0);
    chk("async_rst_vld", 64'(ibuf_vld), 64'd0);
    chk("async_rst_bytes", 64'(ibuf_bytes), 64'd0);
    chk("async_rst_rdy", 64'(ibuf_rdy), 64'd1);
    chk("async_rst_err", 64'(ibuf_err), 64'd0);
    model_step(1'b1, 1'b0, '0, 8'h01, 1'b0, 2'd0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("cnt", 64'(ibuf_cnt), 64'(e.cnt));
      chk("vld", 64'(ibuf_vld), 64'(e.vld));
      chk("bytes", 64'(ibuf_bytes), 64'(e.bytes));
      chk("rdy", 64'(ibuf_rdy), 64'(e.rdy));
      chk("err", 64'(ibuf_err), 64'(e.err));
    end
  end

  initial begin
    logic [7:0] sh;
    cyc(1, 0, '0, 8'h01, 0, 0);
    cyc(1, 0, '0, 8'h01, 0, 0);
    // fill, then shift-with-write
    cyc(0, 1, 32'h11223344, 8'h01, 0, 0);
    cyc(0, 1, 32'h55667788, 8'h01, 0, 0);
    cyc(0, 1, 32'h99AABBCC, 8'b0000_1000, 0, 0);
    cyc(0, 0, '0, 8'h01, 0, 0);
    // reset mid-fill
    cyc(0, 1, 32'hDEADBEEF, 8'h01, 0, 0);
    async_reset_check();
    cyc(1, 1, 32'h01020304, 8'h01, 0, 0);
    // full then wrap
    cyc(0, 1, 32'h00010203, 8'h01, 0, 0);
    cyc(0, 1, 32'h04050607, 8'h01, 0, 0);
    cyc(0, 1, 32'h08090A0B, 8'h01, 0, 0);
    cyc(0, 1, 32'h0C0D0E0F, 8'h01, 0, 0);
    cyc(0, 1, 32'hF0F1F2F3, 8'h01, 0, 0);
    cyc(0, 1, 32'h10111213, 8'h80, 0, 0);
    cyc(0, 1, 32'h14151617, 8'h80, 0, 0);
    cyc(0, 1, 32'h18191A1B, 8'h10, 0, 0);
    cyc(0, 0, '0, 8'h40, 0, 0);
    cyc(0, 0, '0, 8'h01, 0, 0);
    // flush and align, including re-flush while aligning and flush with shift/write
    cyc(0, 1, 32'h12345678, 8'h04, 1, 2'd2);
    cyc(0, 1, 32'hAABBCCDD, 8'h01, 0, 0);
    cyc(0, 0, '0, 8'h01, 1, 2'd1);
    cyc(0, 0, '0, 8'h01, 1, 2'd3);
    cyc(0, 1, 32'hCAFEF00D, 8'h01, 0, 0);
    cyc(0, 1, 32'h5A5A1234, 8'h01, 0, 0);
    // illegal shifts
    cyc(1, 0, '0, 8'h01, 0, 0);
    cyc(0, 1, 32'hA1B2C3D4, 8'h01, 0, 0);
    cyc(0, 0, '0, 8'h02, 0, 0);
    cyc(0, 0, '0, 8'h80, 0, 0);
    cyc(1, 0, '0, 8'h01, 0, 0);
    cyc(0, 1, 32'h0BADF00D, 8'h01, 0, 0);
    cyc(0, 0, '0, 8'b0000_0011, 0, 0);
    cyc(0, 0, '0, 8'h00, 0, 0);
    cyc(1, 0, '0, 8'h01, 0, 0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) sh = 8'($urandom);
      else sh = 8'h01 << $urandom_range(0, 7);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, $urandom, sh,
          $urandom_range(0, 29) == 0, 2'($urandom_range(0, 3)));
    end
    cyc(0, 0, '0, 8'h01, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
